// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master drives bytes and observes writes; slave is the loader itself.
interface imem_loader_if #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(DEPTH) + 2;

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_last;
  logic             byte_ready;
  logic             imem_we;
  logic [AW-1:0]    imem_wr_addr;
  logic [WIDTH-1:0] imem_wr_din;

  modport master (
    output byte_valid, byte_data, byte_last,
    input  byte_ready, imem_we, imem_wr_addr, imem_wr_din
  );

  modport slave (
    input  byte_valid, byte_data, byte_last,
    output byte_ready, imem_we, imem_wr_addr, imem_wr_din
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words for instruction memory, then releases the core.
// Write issues one cycle after the completing byte; byte_ready is high for the whole LOAD state only.
module imem_loader #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  imem_loader_if.slave               bus,
  output logic                       cpu_run,
  output logic                       busy,
  output logic                       error,
  output logic [$clog2(DEPTH):0]     word_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH) + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      word_q, word_d;
  logic [CW-1:0]    wc_q, wc_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             run_q, run_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             accept;
  logic [31:0]      merged;

  assign accept = (state_q == S_LOAD) && bus.byte_valid;
  // Lanes not yet filled stay zero, so a short final word needs no extra masking.
  assign merged = word_q | ({24'd0, bus.byte_data} << {lane_q, 3'b000});

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          lane_d  = 2'd0;
          word_d  = 32'd0;
          wc_d    = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (wc_q == DEPTH_C) begin
            // Memory already full: drop the byte and park in ERR.
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if ((lane_q == 2'd3) || bus.byte_last) begin
            we_d    = 1'b1;
            addr_d  = {wc_q[CW-2:0], 2'b00};
            din_d   = WIDTH'(merged);
            wc_d    = wc_q + CW'(1);
            word_d  = 32'd0;
            lane_d  = 2'd0;
            if (bus.byte_last) begin
              state_d = S_FLUSH;
            end
          end else begin
            word_d = merged;
            lane_d = lane_q + 2'd1;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_FLUSH);
    run_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd0;
      word_q  <= 32'd0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready   = (state_q == S_LOAD);
  assign bus.imem_we      = we_q;
  assign bus.imem_wr_addr = addr_q;
  assign bus.imem_wr_din  = din_q;
  assign cpu_run          = run_q;
  assign busy             = busy_q;
  assign error            = err_q;
  assign word_count       = wc_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued by the stimulus and checked by a write monitor.
module tb_imem_loader;
  localparam int DEPTH = 128;
  localparam int AW    = $clog2(DEPTH) + 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } wr_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          cpu_run;
  logic          busy;
  logic          error;
  logic [CW-1:0] word_count;

  int  vec_cnt = 0;
  int  err_cnt = 0;
  wr_t exp_q[$];

  imem_loader_if #(.DEPTH(DEPTH), .WIDTH(32)) bus ();

  imem_loader #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic run, input logic bsy,
                            input logic err, input logic rdy, input int wc);
    chk({tag, "_cpu_run"},    32'(cpu_run),        32'(run));
    chk({tag, "_busy"},       32'(busy),           32'(bsy));
    chk({tag, "_error"},      32'(error),          32'(err));
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'(rdy));
    chk({tag, "_word_count"}, 32'(word_count),     32'(wc));
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                 bus.imem_wr_addr, bus.imem_wr_din);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imem_wr_addr), 32'(e.addr));
        chk("wr_din",  bus.imem_wr_din,       e.din);
      end
    end
  end

  task automatic push_wr(input int addr, input logic [31:0] din);
    wr_t w;
    w.addr = AW'(addr);
    w.din  = din;
    exp_q.push_back(w);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int budget;
    repeat (gap) begin
      bus.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    bus.byte_last  = last;
    budget = 0;
    while (bus.byte_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL byte_ready_timeout: got no ready within 100 cycles, required ready");
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] prog_a [8];
  logic [7:0] prog_b [6];

  initial begin
    prog_a = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    prog_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_last  = 1'b0;

    // Reset state
    @(negedge clk);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("rst_we",   32'(bus.imem_we),      32'd0);
    chk("rst_addr", 32'(bus.imem_wr_addr), 32'd0);
    chk("rst_din",  bus.imem_wr_din,       32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Two-word program
    push_wr(0, 32'h0000_0013);
    push_wr(4, 32'h0010_0093);
    pulse_start();
    chk_status("loadA", 1'b0, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++) send_byte(prog_a[i], i == 7, 0);
    chk_status("flushA", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    @(negedge clk);
    chk_status("doneA", 1'b1, 1'b0, 1'b0, 1'b0, 2);

    // byte_valid while DONE must be ignored
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hFF;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk_status("doneIgnore", 1'b1, 1'b0, 1'b0, 1'b0, 2);
    drain("A");

    // Reload from DONE with a partial final word
    push_wr(0, 32'hDDCC_BBAA);
    push_wr(4, 32'h0000_2211);
    pulse_start();
    chk_status("reloadB", 1'b0, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) send_byte(prog_b[i], i == 5, 0);
    @(negedge clk);
    chk_status("doneB", 1'b1, 1'b0, 1'b0, 1'b0, 2);
    drain("B");

    // Gapped stream with start held high mid-load
    push_wr(0, 32'h0000_0013);
    push_wr(4, 32'h0010_0093);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) start = 1'b1;
      if (i == 6) start = 1'b0;
      send_byte(prog_a[i], i == 7, (i % 3) + 1);
    end
    @(negedge clk);
    chk_status("doneC", 1'b1, 1'b0, 1'b0, 1'b0, 2);
    drain("C");

    // Reset mid-load, then a fresh load restarts at address 0
    push_wr(0, 32'h0000_0013);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(prog_a[i], 1'b0, 0);
    reset = 1'b0;
    #1;
    chk_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("midrst_we",   32'(bus.imem_we),      32'd0);
    chk("midrst_addr", 32'(bus.imem_wr_addr), 32'd0);
    chk("midrst_din",  bus.imem_wr_din,       32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_wr(0, 32'h4433_2211);
    pulse_start();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b1, 0);
    @(negedge clk);
    chk_status("doneD", 1'b1, 1'b0, 1'b0, 1'b0, 1);
    drain("D");

    // Overflow: DEPTH full words then one more byte without last
    pulse_start();
    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] d;
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(4 * w + k);
      push_wr(4 * w, d);
    end
    for (int i = 0; i < 4 * DEPTH + 1; i++) send_byte(8'(i), 1'b0, 0);
    chk_status("ovf", 1'b0, 1'b0, 1'b1, 1'b0, DEPTH);
    drain("E");
    chk_status("ovfHold", 1'b0, 1'b0, 1'b1, 1'b0, DEPTH);
    @(negedge clk);
    pulse_start();
    chk_status("ovfRecover", 1'b0, 1'b1, 1'b0, 1'b1, 0);

    // Exactly DEPTH words with last on the final byte completes cleanly
    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] d;
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(4 * w + k) ^ 8'h5A;
      push_wr(4 * w, d);
    end
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i) ^ 8'h5A, i == 4 * DEPTH - 1, 0);
    @(negedge clk);
    chk_status("full", 1'b1, 1'b0, 1'b0, 1'b0, DEPTH);
    drain("F");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
